// File: rtl/cu_data_read_line_assembler.sv
// -----------------------------------------------------------------------------
// cu_data_read_line_assembler
//
// Reassembles 128-byte cachelines that come back from memory as two independent
// 64-byte half-beats. Each half is steered into a reassembly slot chosen by the
// low bits of its command tag. A slot whose halves are both present is moved
// into a small output FIFO, lowest slot index first, one line per cycle.
//
// Ports
//   clock, rstn           single clock, asynchronous active-low reset
//   enabled_in            block enable; registered once before it gates capture
//   data_0_*              first half (bytes 0-63) with tag and element count
//   data_1_*              second half (bytes 64-127) with tag
//   line_out_*            assembled line, valid/ready handshake, held while stalled
//   assembler_alfull      registered almost-full used by upstream to throttle
//   elements_done         wrapping 32-bit sum of real_size over popped lines
//   dup_half_error        sticky: a half arrived for a slot that already had it
// -----------------------------------------------------------------------------
module cu_data_read_line_assembler #(
  parameter int SLOTS          = 8,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic          clock,
  input  logic          rstn,
  input  logic          enabled_in,
  input  logic          data_0_valid,
  input  logic [7:0]    data_0_tag,
  input  logic [7:0]    data_0_real_size,
  input  logic [511:0]  data_0_data,
  input  logic          data_1_valid,
  input  logic [7:0]    data_1_tag,
  input  logic [511:0]  data_1_data,
  output logic          line_out_valid,
  input  logic          line_out_ready,
  output logic [1023:0] line_out_data,
  output logic [7:0]    line_out_tag,
  output logic [7:0]    line_out_real_size,
  output logic          assembler_alfull,
  output logic [31:0]   elements_done,
  output logic          dup_half_error
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(OUT_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [7:0]    tag;
    logic [7:0]    size;
    logic [1023:0] data;
  } line_t;

  // Control state (reset)
  logic             enabled_q;
  logic [SLOTS-1:0] h0_q, h0_d, h1_q, h1_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      elements_q, elements_d;
  logic             dup_q, dup_d;
  logic             alfull_q, alfull_d;

  // Payload storage (not reset)
  logic [511:0]     slot_lo_q   [SLOTS];
  logic [511:0]     slot_hi_q   [SLOTS];
  logic [7:0]       slot_tag_q  [SLOTS];
  logic [7:0]       slot_size_q [SLOTS];
  line_t            fifo_mem_q  [OUT_FIFO_DEPTH];

  logic [IW-1:0]    s0_idx, s1_idx, push_sel;
  logic             cap0, cap1, push, pop, found;
  logic [IW:0]      occ_d;
  line_t            head;

  assign s0_idx = data_0_tag[IW-1:0];
  assign s1_idx = data_1_tag[IW-1:0];
  assign head   = fifo_mem_q[rd_ptr_q];
  assign pop    = line_out_valid && line_out_ready;

  // Slot bookkeeping: completion select, capture, duplicate detection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    h0_d     = h0_q;
    h1_d     = h1_q;
    dup_d    = dup_q;
    cap0     = 1'b0;
    cap1     = 1'b0;
    found    = 1'b0;
    push_sel = '0;

    // Descending scan so the lowest complete index is the one left selected.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (h0_q[i] && h1_q[i]) begin
        found    = 1'b1;
        push_sel = IW'(i);
      end
    end
    // Space is judged on the registered count: a pop this cycle never makes
    // room for a push this cycle.
    push = found && (count_q < CW'(OUT_FIFO_DEPTH));
    if (push) begin
      h0_d[push_sel] = 1'b0;
      h1_d[push_sel] = 1'b0;
    end

    // Duplicate checks use the pre-edge flags; a slot being pushed still has
    // both flags set, so a half aimed at it is a duplicate and is dropped.
    if (enabled_q && data_0_valid) begin
      if (h0_q[s0_idx]) dup_d = 1'b1;
      else begin
        cap0         = 1'b1;
        h0_d[s0_idx] = 1'b1;
      end
    end
    if (enabled_q && data_1_valid) begin
      if (h1_q[s1_idx]) dup_d = 1'b1;
      else begin
        cap1         = 1'b1;
        h1_d[s1_idx] = 1'b1;
      end
    end
  end

  // FIFO pointers, count, accumulator and almost-full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(OUT_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(OUT_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    elements_d = elements_q + (pop ? {24'h0, head.size} : 32'h0);

    occ_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (h0_d[i] || h1_d[i]) occ_d = occ_d + (IW+1)'(1);
    end
    // Computed from next-state values so the registered flag lines up with
    // the fill level it describes.
    alfull_d = (count_d >= CW'(OUT_FIFO_DEPTH - 1)) || (occ_d >= (IW+1)'(SLOTS - 2));
  end

  always_ff @(posedge clock or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      enabled_q  <= 1'b0;
      h0_q       <= '0;
      h1_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      elements_q <= '0;
      dup_q      <= 1'b0;
      alfull_q   <= 1'b0;
    end else begin
      enabled_q  <= enabled_in;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      elements_q <= elements_d;
      dup_q      <= dup_d;
      alfull_q   <= alfull_d;
    end
  end

  // NOTE: payload arrays carry no reset; the valid flags and FIFO count
  // decide whether their contents mean anything, so clearing them buys nothing.
  always_ff @(posedge clock) begin
    if (cap1) begin
      slot_hi_q[s1_idx]  <= data_1_data;
      slot_tag_q[s1_idx] <= data_1_tag;
    end
    // Placed after the half-1 write so the half-0 tag wins on a same-slot tie.
    if (cap0) begin
      slot_lo_q[s0_idx]   <= data_0_data;
      slot_tag_q[s0_idx]  <= data_0_tag;
      slot_size_q[s0_idx] <= data_0_real_size;
    end
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= '{tag:  slot_tag_q[push_sel],
                                size: slot_size_q[push_sel],
                                data: {slot_hi_q[push_sel], slot_lo_q[push_sel]}};
    end
  end

  // Outputs are forced to zero when nothing is queued, which also keeps them
  // at zero during reset even though the storage itself is not cleared.
  assign line_out_valid     = (count_q != '0);
  assign line_out_data      = line_out_valid ? head.data : '0;
  assign line_out_tag       = line_out_valid ? head.tag  : '0;
  assign line_out_real_size = line_out_valid ? head.size : '0;
  assign assembler_alfull   = alfull_q;
  assign elements_done      = elements_q;
  assign dup_half_error     = dup_q;

endmodule

// File: tb/tb_cu_data_read_line_assembler.sv
module tb_cu_data_read_line_assembler;

  localparam int SLOTS = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]    tag;
    logic [7:0]    size;
    logic [1023:0] data;
  } line_t;

  logic          clock = 1'b0;
  logic          rstn;
  logic          enabled_in;
  logic          data_0_valid;
  logic [7:0]    data_0_tag;
  logic [7:0]    data_0_real_size;
  logic [511:0]  data_0_data;
  logic          data_1_valid;
  logic [7:0]    data_1_tag;
  logic [511:0]  data_1_data;
  logic          line_out_valid;
  logic          line_out_ready;
  logic [1023:0] line_out_data;
  logic [7:0]    line_out_tag;
  logic [7:0]    line_out_real_size;
  logic          assembler_alfull;
  logic [31:0]   elements_done;
  logic          dup_half_error;

  int tests  = 0;
  int failed = 0;

  cu_data_read_line_assembler #(.SLOTS(SLOTS), .OUT_FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .data_0_valid(data_0_valid), .data_0_tag(data_0_tag),
    .data_0_real_size(data_0_real_size), .data_0_data(data_0_data),
    .data_1_valid(data_1_valid), .data_1_tag(data_1_tag), .data_1_data(data_1_data),
    .line_out_valid(line_out_valid), .line_out_ready(line_out_ready),
    .line_out_data(line_out_data), .line_out_tag(line_out_tag),
    .line_out_real_size(line_out_real_size), .assembler_alfull(assembler_alfull),
    .elements_done(elements_done), .dup_half_error(dup_half_error)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: a set of half-line buckets keyed by slot and a queue of
  // finished lines. Updated once per rising edge from the inputs seen there.
  // ---------------------------------------------------------------------------
  bit           m_en;
  bit           m_h0 [SLOTS];
  bit           m_h1 [SLOTS];
  logic [7:0]   m_tag [SLOTS];
  logic [7:0]   m_size [SLOTS];
  logic [511:0] m_lo [SLOTS];
  logic [511:0] m_hi [SLOTS];
  line_t        m_q [$];
  logic [31:0]  m_elem;
  bit           m_dup;
  bit           m_alfull;
  logic [7:0]   popped_tags [$];
  logic [511:0] last_d0;

  task automatic model_reset();
    m_en = 0; m_elem = 0; m_dup = 0; m_alfull = 0;
    m_q.delete();
    for (int i = 0; i < SLOTS; i++) begin m_h0[i] = 0; m_h1[i] = 0; end
  endtask

  task automatic model_step();
    int    old_cnt;
    int    pidx;
    int    occ;
    int    s;
    line_t pl;
    old_cnt = m_q.size();
    pidx = -1;
    if (old_cnt < DEPTH)
      for (int i = 0; i < SLOTS; i++)
        if (pidx < 0 && m_h0[i] && m_h1[i]) pidx = i;
    if (pidx >= 0) pl = '{m_tag[pidx], m_size[pidx], {m_hi[pidx], m_lo[pidx]}};
    if (m_en) begin
      if (data_1_valid) begin
        s = data_1_tag % SLOTS;
        if (m_h1[s]) m_dup = 1;
        else begin m_h1[s] = 1; m_hi[s] = data_1_data; m_tag[s] = data_1_tag; end
      end
      if (data_0_valid) begin
        s = data_0_tag % SLOTS;
        if (m_h0[s]) m_dup = 1;
        else begin
          m_h0[s] = 1; m_lo[s] = data_0_data;
          m_tag[s] = data_0_tag; m_size[s] = data_0_real_size;
        end
      end
    end
    if (old_cnt > 0 && line_out_ready) begin
      m_elem = m_elem + 32'(m_q[0].size);
      popped_tags.push_back(m_q[0].tag);
      void'(m_q.pop_front());
    end
    if (pidx >= 0) begin
      m_h0[pidx] = 0; m_h1[pidx] = 0;
      m_q.push_back(pl);
    end
    occ = 0;
    for (int i = 0; i < SLOTS; i++) if (m_h0[i] || m_h1[i]) occ++;
    m_alfull = (m_q.size() >= DEPTH - 1) || (occ >= SLOTS - 2);
    m_en = enabled_in;
  endtask

  function automatic line_t m_head();
    line_t z;
    z = '0;
    if (m_q.size() > 0) z = m_q[0];
    return z;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (rstn) model_step();
    @(negedge clock);
  endtask

  task automatic step(input bit v0, input logic [7:0] t0, input logic [7:0] s0,
                      input bit v1, input logic [7:0] t1);
    data_0_valid = v0; data_0_tag = t0; data_0_real_size = s0; data_0_data = rnd512();
    data_1_valid = v1; data_1_tag = t1; data_1_data = rnd512();
    last_d0 = data_0_data;
    tick();
    data_0_valid = 0; data_1_valid = 0;
  endtask

  // Observe n cycles, comparing every output against the model each cycle.
  task automatic observe(input string name, input int n);
    line_t h;
    for (int c = 0; c < n; c++) begin
      tick();
      h = m_head();
      tests++;
      if ({line_out_valid, line_out_tag, line_out_real_size} !==
          {m_q.size() > 0, h.tag, h.size}) begin
        failed++;
        $display("FAIL %s head cyc%0d got v=%b tag=%h sz=%h exp v=%b tag=%h sz=%h", name, c,
                 line_out_valid, line_out_tag, line_out_real_size, m_q.size() > 0, h.tag, h.size);
      end
      tests++;
      if (line_out_data !== h.data) begin
        failed++;
        $display("FAIL %s data cyc%0d got %h exp %h", name, c, line_out_data[63:0], h.data[63:0]);
      end
      tests++;
      if ({elements_done, dup_half_error, assembler_alfull} !== {m_elem, m_dup, m_alfull}) begin
        failed++;
        $display("FAIL %s status cyc%0d got elem=%h dup=%b af=%b exp elem=%h dup=%b af=%b",
                 name, c, elements_done, dup_half_error, assembler_alfull, m_elem, m_dup, m_alfull);
      end
    end
  endtask

  task automatic enable_and_settle();
    enabled_in = 1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 0; enabled_in = 1; line_out_ready = 1;
    data_0_valid = 1; data_0_tag = 8'h01; data_0_real_size = 8'h10; data_0_data = rnd512();
    data_1_valid = 1; data_1_tag = 8'h01; data_1_data = rnd512();
    model_reset();
    repeat (3) @(negedge clock);
    tests++;
    if ({line_out_valid, line_out_tag, line_out_real_size, assembler_alfull, elements_done,
         dup_half_error} !== '0 || line_out_data !== '0) begin
      failed++;
      $display("FAIL reset_outputs got v=%b tag=%h af=%b elem=%h dup=%b exp all zero",
               line_out_valid, line_out_tag, assembler_alfull, elements_done, dup_half_error);
    end
    data_0_valid = 0; data_1_valid = 0; enabled_in = 0;
    rstn = 1;
    observe("reset_idle", 2);
  endtask

  task automatic test_basic();
    line_t exp_line;
    logic [511:0] lo;
    line_out_ready = 1;
    enable_and_settle();
    step(1, 8'h05, 8'd32, 0, 8'h00);
    lo = last_d0;
    step(0, 8'h00, 8'h00, 0, 8'h00);
    step(0, 8'h00, 8'h00, 1, 8'h05);
    exp_line = '{8'h05, 8'd32, {data_1_data, lo}};
    tick();  // one edge after the second half: line must be visible now
    tests++;
    if (line_out_valid !== 1'b1 || line_out_tag !== 8'h05 || line_out_data !== exp_line.data) begin
      failed++;
      $display("FAIL basic_latency got v=%b tag=%h exp v=1 tag=05", line_out_valid, line_out_tag);
    end
    observe("basic", 3);
    tests++;
    if (elements_done !== 32'd32) begin
      failed++;
      $display("FAIL basic_elements got %0d exp 32", elements_done);
    end
  endtask

  task automatic test_interleave();
    popped_tags.delete();
    step(1, 8'h01, 8'd4, 0, 8'h00);
    step(1, 8'h02, 8'd5, 0, 8'h00);
    step(0, 8'h00, 8'h00, 1, 8'h02);
    step(0, 8'h00, 8'h00, 1, 8'h01);
    observe("interleave", 5);
    tests++;
    if (popped_tags.size() != 2 || popped_tags[0] !== 8'h02 || popped_tags[1] !== 8'h01
        || dup_half_error !== 1'b0) begin
      failed++;
      $display("FAIL interleave_order got n=%0d dup=%b exp tags 02,01 no error",
               popped_tags.size(), dup_half_error);
    end
  endtask

  task automatic test_backpressure();
    popped_tags.delete();
    line_out_ready = 0;
    for (int t = 0; t < 6; t++) step(1, 8'(8'h10 + t), 8'd1, 1, 8'(8'h10 + t));
    observe("bp_fill", 4);
    tests++;
    if (m_q.size() != DEPTH || assembler_alfull !== 1'b1 || line_out_tag !== 8'h10) begin
      failed++;
      $display("FAIL bp_full got af=%b tag=%h exp af=1 tag=10 (model depth %0d)",
               assembler_alfull, line_out_tag, m_q.size());
    end
    line_out_ready = 1;
    observe("bp_drain", 10);
    tests++;
    if (popped_tags.size() != 6 || assembler_alfull !== 1'b0 || line_out_valid !== 1'b0) begin
      failed++;
      $display("FAIL bp_drained got n=%0d af=%b v=%b exp n=6 af=0 v=0",
               popped_tags.size(), assembler_alfull, line_out_valid);
    end
    for (int i = 0; i < popped_tags.size(); i++) begin
      tests++;
      if (popped_tags[i] !== 8'(8'h10 + i)) begin
        failed++;
        $display("FAIL bp_order idx%0d got %h exp %h", i, popped_tags[i], 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_wrap();
    line_out_ready = 0;
    force dut.elements_q = 32'hFFFF_FFF0;
    tick();
    release dut.elements_q;
    m_elem = 32'hFFFF_FFF0;
    for (int t = 0; t < 8; t++) step(1, 8'(t), 8'd32, 1, 8'(t));
    line_out_ready = 1;
    observe("wrap", 14);
    tests++;
    if (elements_done !== 32'h0000_00F0) begin
      failed++;
      $display("FAIL wrap_elements got %h exp 000000f0", elements_done);
    end
  endtask

  task automatic test_dup();
    logic [511:0] first;
    line_out_ready = 1;
    step(1, 8'h03, 8'd7, 0, 8'h00);
    first = last_d0;
    step(1, 8'h03, 8'd9, 0, 8'h00);
    step(0, 8'h00, 8'h00, 1, 8'h03);
    tick();
    tests++;
    if (line_out_data[511:0] !== first || line_out_real_size !== 8'd7 || dup_half_error !== 1'b1) begin
      failed++;
      $display("FAIL dup_keep got sz=%0d dup=%b exp sz=7 dup=1", line_out_real_size, dup_half_error);
    end
    observe("dup", 5);
    tests++;
    if (dup_half_error !== 1'b1) begin
      failed++;
      $display("FAIL dup_sticky got %b exp 1", dup_half_error);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    line_out_ready = 0;
    for (int t = 4; t < 7; t++) step(1, 8'(t), 8'd2, 1, 8'(t));
    step(1, 8'h00, 8'd2, 1, 8'h01);
    observe("rmid_fill", 2);
    #2 rstn = 0;
    model_reset();
    #1;
    tests++;
    if ({line_out_valid, line_out_tag, line_out_real_size, assembler_alfull, elements_done,
         dup_half_error} !== '0 || line_out_data !== '0) begin
      failed++;
      $display("FAIL rmid_zero got v=%b af=%b elem=%h dup=%b exp all zero",
               line_out_valid, assembler_alfull, elements_done, dup_half_error);
    end
    @(negedge clock);
    rstn = 1;
    line_out_ready = 1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (line_out_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      failed++;
      $display("FAIL rmid_stale got %0d valid cycles exp 0", seen);
    end
    observe("rmid_after", 2);
  endtask

  task automatic test_back_to_back();
    line_out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      data_0_valid = 1; data_0_tag = 8'(i % SLOTS); data_0_real_size = 8'($urandom_range(0, 255));
      data_0_data = rnd512();
      data_1_valid = 1; data_1_tag = 8'(i % SLOTS); data_1_data = rnd512();
      observe("b2b", 1);
    end
    data_0_valid = 0; data_1_valid = 0;
    observe("b2b_tail", 6);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) enabled_in = ~enabled_in;
      line_out_ready   = ($urandom_range(0, 3) != 0);
      data_0_valid     = ($urandom_range(0, 2) == 0);
      data_0_tag       = 8'($urandom_range(0, SLOTS - 1));
      data_0_real_size = 8'($urandom);
      data_0_data      = rnd512();
      data_1_valid     = ($urandom_range(0, 2) == 0);
      data_1_tag       = 8'($urandom_range(0, SLOTS - 1));
      data_1_data      = rnd512();
      observe("random", 1);
    end
    data_0_valid = 0; data_1_valid = 0; enabled_in = 0; line_out_ready = 1;
    observe("random_drain", 12);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_dup();
    test_reset_mid();
    enabled_in = 1;
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
